// File: rtl/stepper_step_gen.sv
// stepper_step_gen: per-axis step/dir/enable pulse generator driven by move
// commands over a valid/ready handshake. Guarantees a fixed step high time,
// dir-to-step setup after a direction change, and exact rise spacing.
// Optional build macro: STEPGEN_ENDSTOP_EN adds a synchronized endstop input
// that aborts moves heading in ENDSTOP_DIR.
module stepper_step_gen #(
    parameter int unsigned PULSE_W     = 10,
    parameter int unsigned DIR_SETUP   = 25,
    parameter int unsigned STEPS_W     = 24,
    parameter int unsigned PERIOD_W    = 24,
`ifdef STEPGEN_ENDSTOP_EN
    parameter bit          ENDSTOP_DIR = 1'b0,
`endif
    parameter int unsigned POS_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_in,
`ifdef STEPGEN_ENDSTOP_EN
    input  logic                endstop,
`endif
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [STEPS_W-1:0]  cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    output logic                step,
    output logic                dir,
    output logic                enable,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [POS_W-1:0]    position
);

    localparam int unsigned MIN_P = 2 * PULSE_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIR_SETUP,
        S_PULSE,
        S_WAIT
    } state_t;

    state_t              state;
    logic [STEPS_W-1:0]  steps_left;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] cnt;

    logic                accept_c;
    logic                stop_c;
    logic                es_hit_c;
    logic                es_block_c;
    logic [PERIOD_W-1:0] period_eff_c;
    logic [POS_W-1:0]    pos_step_c;

`ifdef STEPGEN_ENDSTOP_EN
    logic [1:0] es_sync;

    // Two-flop synchronizer for the asynchronous endstop switch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            es_sync <= 2'b00;
        end else begin
            es_sync <= {es_sync[0], endstop};
        end
    end

    assign es_hit_c   = es_sync[1] & (dir == ENDSTOP_DIR);
    assign es_block_c = es_sync[1] & (cmd_dir == ENDSTOP_DIR);
`else
    assign es_hit_c   = 1'b0;
    assign es_block_c = 1'b0;
`endif

    // Handshake, abort request, clamped period and next position
    assign cmd_ready    = (state == S_IDLE) & en_in & ~rst;
    assign accept_c     = cmd_valid & cmd_ready;
    assign stop_c       = ~en_in | es_hit_c;
    assign period_eff_c = (cmd_period < PERIOD_W'(MIN_P)) ? PERIOD_W'(MIN_P) : cmd_period;
    assign pos_step_c   = dir ? (position + POS_W'(1)) : (position - POS_W'(1));

    // Move sequencer: setup, pulse high time, period wait, completion/abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            step       <= 1'b0;
            dir        <= 1'b0;
            enable     <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            position   <= '0;
            steps_left <= '0;
            period_q   <= '0;
            cnt        <= '0;
        end else begin
            enable  <= ~en_in;
            done    <= 1'b0;
            aborted <= 1'b0;

            if ((state != S_IDLE) && stop_c) begin
                // Disable or endstop: cut any pulse short and drop the move
                state      <= S_IDLE;
                step       <= 1'b0;
                busy       <= 1'b0;
                aborted    <= 1'b1;
                steps_left <= '0;
                cnt        <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept_c) begin
                            if (cmd_steps == '0) begin
                                done <= 1'b1;
                            end else if (es_block_c) begin
                                aborted <= 1'b1;
                            end else begin
                                busy     <= 1'b1;
                                period_q <= period_eff_c;
                                cnt      <= PERIOD_W'(1);
                                if (cmd_dir != dir) begin
                                    dir        <= cmd_dir;
                                    steps_left <= cmd_steps;
                                    state      <= S_DIR_SETUP;
                                end else begin
                                    step       <= 1'b1;
                                    position   <= pos_step_c;
                                    steps_left <= cmd_steps - STEPS_W'(1);
                                    state      <= S_PULSE;
                                end
                            end
                        end
                    end

                    S_DIR_SETUP: begin
                        if (cnt == PERIOD_W'(DIR_SETUP)) begin
                            step       <= 1'b1;
                            position   <= pos_step_c;
                            steps_left <= steps_left - STEPS_W'(1);
                            cnt        <= PERIOD_W'(1);
                            state      <= S_PULSE;
                        end else begin
                            cnt <= cnt + PERIOD_W'(1);
                        end
                    end

                    S_PULSE: begin
                        if (cnt == PERIOD_W'(PULSE_W)) begin
                            step  <= 1'b0;
                            state <= S_WAIT;
                        end
                        cnt <= cnt + PERIOD_W'(1);
                    end

                    S_WAIT: begin
                        if (cnt == period_q) begin
                            if (steps_left == '0) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                cnt   <= '0;
                                state <= S_IDLE;
                            end else begin
                                step       <= 1'b1;
                                position   <= pos_step_c;
                                steps_left <= steps_left - STEPS_W'(1);
                                cnt        <= PERIOD_W'(1);
                                state      <= S_PULSE;
                            end
                        end else begin
                            cnt <= cnt + PERIOD_W'(1);
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stepper_step_gen.sv
// Randomized bench for stepper_step_gen: every move is predicted from the
// command alone (rise times, pulse windows, done/abort cycles, position).
module tb_stepper_step_gen;

    localparam int unsigned PULSE_W   = 10;
    localparam int unsigned DIR_SETUP = 25;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_in;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [23:0] cmd_steps;
    logic [23:0] cmd_period;
    logic        step;
    logic        dir;
    logic        enable;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [31:0] position;
`ifdef STEPGEN_ENDSTOP_EN
    logic        endstop;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic        m_dir;
    logic [31:0] m_pos;

    stepper_step_gen dut (
        .clk        (clk),
        .rst        (rst),
        .en_in      (en_in),
`ifdef STEPGEN_ENDSTOP_EN
        .endstop    (endstop),
`endif
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .step       (step),
        .dir        (dir),
        .enable     (enable),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .position   (position)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int budget;
        budget = 0;
        while (cmd_ready !== 1'b1 && budget < 50) begin
            tick();
            budget++;
        end
        check("ready_wait", 64'(cmd_ready), 64'd1);
    endtask

    // One command; abort_at = cycle (1 = first cycle after accept) in which
    // en_in is held low, -1 = no abort, -2 = random point inside the move.
    task automatic run_move(input logic d, input int n, input int per, input int abort_req);
        int          p;
        int          rise0;
        int          fin;
        int          abort_at;
        int          nr;
        logic        st;
        logic        busy_e;
        logic        done_e;
        logic        ab_e;
        logic        en_e;
        logic        dir_e;
        logic [31:0] pos0;
        logic [31:0] pos_e;

        wait_ready();
        p     = (per < int'(2 * PULSE_W)) ? int'(2 * PULSE_W) : per;
        rise0 = (n > 0 && d != m_dir) ? 1 + int'(DIR_SETUP) : 1;
        fin   = (n > 0) ? rise0 + n * p : 1;
        abort_at = abort_req;
        if (abort_req == -2)
            abort_at = (n > 0) ? int'($urandom_range(fin - 1, 1)) : -1;
        pos0  = m_pos;
        pos_e = pos0;

        cmd_valid  = 1'b1;
        cmd_dir    = d;
        cmd_steps  = 24'(n);
        cmd_period = 24'(per);
        tick();
        cmd_valid  = 1'b0;

        for (int c = 1; c <= fin + 2; c++) begin
            en_in = (c == abort_at) ? 1'b0 : 1'b1;
            nr = 0;
            st = 1'b0;
            for (int k = 0; k < n; k++) begin
                if ((rise0 + k * p) <= c && (abort_at < 0 || (rise0 + k * p) <= abort_at)) begin
                    nr++;
                    if (c < rise0 + k * p + int'(PULSE_W) && (abort_at < 0 || c <= abort_at))
                        st = 1'b1;
                end
            end
            busy_e = (n > 0) && (c < fin) && (abort_at < 0 || c <= abort_at);
            done_e = (c == fin) && (abort_at < 0 || fin <= abort_at);
            ab_e   = (n > 0) && (abort_at >= 1) && (abort_at < fin) && (c == abort_at + 1);
            en_e   = (abort_at >= 1) && (c == abort_at + 1);
            dir_e  = (n > 0) ? d : m_dir;
            pos_e  = d ? (pos0 + 32'(nr)) : (pos0 - 32'(nr));
            check("outputs{step,busy,done,aborted,dir,enable}",
                  64'({step, busy, done, aborted, dir, enable}),
                  64'({st, busy_e, done_e, ab_e, dir_e, en_e}));
            check("position", 64'(position), 64'(pos_e));
            if (abort_at < 0 && c == fin)
                check("ready_at_done", 64'(cmd_ready), 64'd1);
            tick();
        end
        en_in = 1'b1;
        m_pos = pos_e;
        if (n > 0) m_dir = d;
    endtask

    task automatic reset_mid_move();
        wait_ready();
        cmd_valid  = 1'b1;
        cmd_dir    = ~m_dir;
        cmd_steps  = 24'd3;
        cmd_period = 24'd30;
        tick();
        cmd_valid  = 1'b0;
        repeat (40) tick();
        check("busy_before_rst", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_outputs", 64'({step, busy, done, aborted, dir, enable}), 64'(6'b000001));
        check("rst_async_position", 64'(position), 64'd0);
        check("rst_ready", 64'(cmd_ready), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("enable_after_rst", 64'(enable), 64'd0);
        m_pos = '0;
        m_dir = 1'b0;
    endtask

`ifdef STEPGEN_ENDSTOP_EN
    task automatic endstop_test();
        int   rises;
        int   cyc;
        int   hit_cyc;
        int   ab_cyc;
        logic prev;
        logic seen_done;
        logic seen_ab;

        wait_ready();
        cmd_valid  = 1'b1;
        cmd_dir    = 1'b0;
        cmd_steps  = 24'd100;
        cmd_period = 24'd20;
        tick();
        cmd_valid  = 1'b0;
        rises = 0; cyc = 0; hit_cyc = -1; ab_cyc = -1; prev = 1'b0;
        while (cyc < 3000 && ab_cyc < 0 && done !== 1'b1) begin
            if (aborted === 1'b1) ab_cyc = cyc;
            else begin
                if (step === 1'b1 && prev === 1'b0) begin
                    rises++;
                    if (rises == 4) begin
                        endstop = 1'b1;
                        hit_cyc = cyc;
                    end
                end
                prev = step;
                tick();
                cyc++;
            end
        end
        check("es_abort_seen", 64'(ab_cyc >= 0), 64'd1);
        check("es_abort_within_3", 64'((ab_cyc - hit_cyc) <= 3), 64'd1);
        check("es_rises", 64'(rises), 64'd4);
        check("es_position", 64'(position), 64'(m_pos - 32'd4));
        m_pos = m_pos - 32'd4;
        m_dir = 1'b0;

        wait_ready();
        cmd_valid  = 1'b1;
        cmd_dir    = 1'b1;
        cmd_steps  = 24'd100;
        cmd_period = 24'd20;
        tick();
        cmd_valid  = 1'b0;
        rises = 0; cyc = 0; prev = 1'b0; seen_done = 1'b0; seen_ab = 1'b0;
        while (cyc < 3000 && !seen_done) begin
            if (aborted === 1'b1) seen_ab = 1'b1;
            if (done === 1'b1) seen_done = 1'b1;
            if (step === 1'b1 && prev === 1'b0) rises++;
            prev = step;
            tick();
            cyc++;
        end
        check("es_backoff_done", 64'(seen_done), 64'd1);
        check("es_backoff_no_abort", 64'(seen_ab), 64'd0);
        check("es_backoff_rises", 64'(rises), 64'd100);
        check("es_backoff_position", 64'(position), 64'(m_pos + 32'd100));
        m_pos = m_pos + 32'd100;
        m_dir = 1'b1;
        endstop = 1'b0;
    endtask
`endif

    initial begin
        rst        = 1'b1;
        en_in      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_dir    = 1'b0;
        cmd_steps  = '0;
        cmd_period = '0;
`ifdef STEPGEN_ENDSTOP_EN
        endstop    = 1'b0;
`endif
        m_dir = 1'b0;
        m_pos = '0;

        repeat (3) tick();
        check("reset_outputs", 64'({step, busy, done, aborted, dir, enable}), 64'(6'b000001));
        check("reset_position", 64'(position), 64'd0);
        check("reset_ready", 64'(cmd_ready), 64'd0);
        rst = 1'b0;
        tick();
        check("enable_while_en_low", 64'(enable), 64'd1);
        en_in = 1'b1;
        tick();
        check("enable_after_en", 64'(enable), 64'd0);

        // Direction change with setup, then same-direction clamped period
        run_move(1'b1, 3, 100, -1);
        run_move(1'b1, 2, 5, -1);
        // Zero-step commands
        run_move(1'b0, 0, 37, -1);
        run_move(1'b1, 0, 0, -1);
        // Bring position to -1, then step through zero
        run_move(1'b0, 6, 0, -1);
        check("preload_minus_one", 64'(position), 64'hFFFF_FFFF);
        run_move(1'b1, 2, 0, -1);
        // Disable during the second high pulse of a 5-step move
        run_move(1'b1, 5, 0, 1 + 20 + 3);
        // Randomized moves, some aborted
        for (int i = 0; i < 30; i++) begin
            run_move(1'($urandom_range(1, 0)), int'($urandom_range(4, 0)),
                     int'($urandom_range(60, 0)),
                     ($urandom_range(3, 0) == 0) ? -2 : -1);
        end
        reset_mid_move();
        run_move(1'b1, 2, 33, -1);
`ifdef STEPGEN_ENDSTOP_EN
        endstop_test();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
